// File: rtl/bp_debounce.sv
// Push-button front end: two-flop synchroniser, per-channel debounce and press/release pulses.
// Optional long-press detector is compiled in with BP_LONG_PRESS_EN.
module bp_debounce #(
   parameter int N_BTN           = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter int ACTIVE_LOW      = 1,
   parameter int LONG_CYCLES     = 50000000,
   parameter int LONG_W          = 26
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pressed,
   output logic [N_BTN-1:0] btn_released,
   output logic [N_BTN-1:0] btn_long
);

   localparam logic             IDLE_BIT = (ACTIVE_LOW != 0);
   localparam logic [N_BTN-1:0] IDLE_VEC = {N_BTN{IDLE_BIT}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Parameter sanity: counters must hold their terminal values.
   if (DEBOUNCE_CYCLES < 2 || (2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cnt_w
      $error("bp_debounce: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
   end
   if (LONG_CYCLES < 1 || (2 ** LONG_W) <= LONG_CYCLES) begin : g_bad_long_w
      $error("bp_debounce: LONG_CYCLES must be >= 1 and fit in LONG_W bits");
   end

   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] sync2;
   logic [CNT_W-1:0] cnt [N_BTN];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1        <= IDLE_VEC;
         sync2        <= IDLE_VEC;
         btn_level    <= IDLE_VEC;
         btn_pressed  <= '0;
         btn_released <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         for (int i = 0; i < N_BTN; i++) begin
            btn_pressed[i]  <= 1'b0;
            btn_released[i] <= 1'b0;
            if (sync2[i] == btn_level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] < CNT_LAST) begin
               cnt[i] <= cnt[i] + 1'b1;
            end else begin
               // Input held opposite for the full window: accept it.
               btn_level[i] <= sync2[i];
               cnt[i]       <= '0;
               if (sync2[i] != IDLE_BIT) begin
                  btn_pressed[i] <= 1'b1;
               end else begin
                  btn_released[i] <= 1'b1;
               end
            end
         end
      end
   end

`ifdef BP_LONG_PRESS_EN
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
   localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

   logic [LONG_W-1:0] hold_cnt [N_BTN];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_long <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            hold_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            btn_long[i] <= 1'b0;
            if (btn_level[i] == IDLE_BIT) begin
               hold_cnt[i] <= '0;
            end else if (hold_cnt[i] == LONG_LAST) begin
               // Park one past the terminal count so the pulse cannot repeat.
               hold_cnt[i] <= LONG_SAT;
               btn_long[i] <= 1'b1;
            end else if (hold_cnt[i] < LONG_LAST) begin
               hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   assign btn_long = '0;
`endif

endmodule

// File: tb/tb_bp_debounce.sv
// Bench for bp_debounce: directed scenarios plus random key activity, every cycle compared
// against a window-based reference model of the accepted levels and pulses.
module tb_bp_debounce;

   localparam int N    = 2;
   localparam int D    = 8;
   localparam int CW   = 4;
   localparam int L    = 20;
   localparam int LW   = 5;
   localparam int HMAX = 8192;
`ifdef BP_LONG_PRESS_EN
   localparam bit LONG_ON = 1'b1;
`else
   localparam bit LONG_ON = 1'b0;
`endif

   logic         clk     = 1'b0;
   logic         reset_n = 1'b0;
   logic [N-1:0] btn_raw = 2'b00;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_pressed;
   logic [N-1:0] btn_released;
   logic [N-1:0] btn_long;

   bp_debounce #(
      .N_BTN           (N),
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (CW),
      .ACTIVE_LOW      (1),
      .LONG_CYCLES     (L),
      .LONG_W          (LW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .btn_raw      (btn_raw),
      .btn_level    (btn_level),
      .btn_pressed  (btn_pressed),
      .btn_released (btn_released),
      .btn_long     (btn_long)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: the raw value sampled at each edge since reset is kept in hist[].
   // An edge accepts a new level when the synchronised input seen over the last D edges
   // all differed from the level and no acceptance happened in that window.
   logic [N-1:0] hist [HMAX];
   int           t;
   logic [N-1:0] m_lvl, m_p, m_r, m_l;
   int           lf [N];
   int           dl [N];

   function automatic logic s2(input int e, input int b);
      if (e >= 2) return hist[e-2][b];
      return 1'b1;
   endfunction

   task automatic model_reset();
      t     = 0;
      m_lvl = 2'b11;
      for (int b = 0; b < N; b++) begin
         lf[b] = -1;
         dl[b] = -1;
      end
   endtask

   task automatic model_edge();
      bit ok;
      m_p = '0;
      m_r = '0;
      m_l = '0;
      for (int b = 0; b < N; b++) begin
         if (dl[b] == t) m_l[b] = LONG_ON;
         ok = (t - lf[b] >= D);
         for (int k = 0; k < D; k++) begin
            if (s2(t - k, b) == m_lvl[b]) ok = 1'b0;
         end
         if (ok) begin
            m_lvl[b] = ~m_lvl[b];
            lf[b]    = t;
            if (m_lvl[b] == 1'b0) begin
               m_p[b] = 1'b1;
               dl[b]  = t + L;
            end else begin
               m_r[b] = 1'b1;
               dl[b]  = -1;
            end
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      if (t >= HMAX) begin
         $display("FAIL hist_overflow: got=%0d expected<%0d", t, HMAX);
         $fatal(1, "history overflow");
      end
      hist[t] = btn_raw;
      model_edge();
      #1;
      chk("outs", int'({btn_level, btn_pressed, btn_released, btn_long}),
          int'({m_lvl, m_p, m_r, m_l}));
      t++;
   endtask

   int e0, pe, le, np, nl, n1, both;

   initial begin
      model_reset();
      btn_raw = 2'b00;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_level", int'(btn_level), 3);
      chk("rst_pulses", int'({btn_pressed, btn_released, btn_long}), 0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      repeat (5) cyc();
      btn_raw = 2'b11;
      repeat (12) cyc();
      chk("rst_hold", int'(btn_level), 3);

      // clean press on bit 0
      btn_raw = 2'b10;
      e0 = t; pe = -1000; np = 0; n1 = 0;
      repeat (20) begin
         cyc();
         if (btn_pressed[0]) begin np++; pe = t - 1; end
         if (btn_pressed[1] || btn_released[1] || !btn_level[1]) n1++;
      end
      chk("press_lat", pe - e0, 9);
      chk("press_cnt", np, 1);
      chk("bit1_quiet", n1, 0);
      btn_raw = 2'b11;
      repeat (15) cyc();

      // bounce then settle pressed
      np = 0;
      for (int i = 0; i < 10; i++) begin
         btn_raw[0] = i[0];
         for (int j = 0; j < 3; j++) begin
            cyc();
            if (btn_pressed[0] || btn_released[0]) np++;
         end
      end
      chk("bounce_quiet", np, 0);
      btn_raw[0] = 1'b0;
      e0 = t; pe = -1000; np = 0;
      repeat (20) begin
         cyc();
         if (btn_pressed[0]) begin np++; pe = t - 1; end
      end
      chk("bounce_lat", pe - e0, 9);
      chk("bounce_cnt", np, 1);
      btn_raw = 2'b11;
      repeat (15) cyc();

      // simultaneous press, then release bit 1
      btn_raw = 2'b00;
      e0 = t; both = -1000;
      repeat (12) begin
         cyc();
         if (btn_pressed == 2'b11) both = t - 1;
      end
      chk("simul_press", both - e0, 9);
      btn_raw = 2'b10;
      n1 = 0;
      repeat (15) begin
         cyc();
         if (btn_released[1]) n1++;
      end
      chk("rel1_cnt", n1, 1);
      chk("simul_level", int'(btn_level), 2);
      btn_raw = 2'b11;
      repeat (15) cyc();

      // long hold on bit 0
      btn_raw = 2'b10;
      pe = -1000; le = -1000; nl = 0;
      repeat (50) begin
         cyc();
         if (btn_pressed[0]) pe = t - 1;
         if (btn_long[0]) begin nl++; le = t - 1; end
      end
      btn_raw = 2'b11;
      repeat (15) begin
         cyc();
         if (btn_long != 2'b00) nl++;
      end
      if (LONG_ON) begin
         chk("long_cnt", nl, 1);
         chk("long_delay", le - pe, 20);
      end else begin
         chk("long_zero", nl, 0);
      end

      // random key activity
      repeat (120) begin
         btn_raw = 2'($urandom);
         repeat ($urandom_range(1, 30)) cyc();
      end
      btn_raw = 2'b11;
      repeat (15) cyc();

      // reset mid-count, keys back to idle
      btn_raw = 2'b10;
      repeat (7) cyc();
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_level", int'(btn_level), 3);
      chk("mid_rst_pulse", int'({btn_pressed, btn_released, btn_long}), 0);
      btn_raw = 2'b11;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      np = 0;
      repeat (20) begin
         cyc();
         if ({btn_pressed, btn_released, btn_long} != '0) np++;
      end
      chk("post_rst_quiet", np, 0);

      // reset mid-count with key still held: full window needed afterwards
      btn_raw = 2'b10;
      repeat (7) cyc();
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst2_level", int'(btn_level), 3);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      e0 = t; pe = -1000;
      repeat (20) begin
         cyc();
         if (btn_pressed[0]) pe = t - 1;
      end
      chk("post_rst_lat", pe - e0, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
